// File: rtl/tx_serdes_pkg.sv
// Shared types and constants for the 10-bit TX serializer path.
// K28.5 comma constants, FSM state type and the symbol ones counter.
package tx_serdes_pkg;

   localparam int SYM_W = 10;
   localparam int CNT_W = 4;

   localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } tx_state_e;

   function automatic logic [3:0] ones_cnt10(
      input logic [9:0] s
   );
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 10; i++) begin
         c = c + {3'b000, s[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/tx_sym_fifo.sv
// Small symbol buffer between the encoder and the serializer.
// Power-of-two depth; pushes ignored when full, pops when empty.
module tx_sym_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = tx_serdes_pkg::SYM_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             push_w;
   logic             pop_w;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_w  = push_i && !full_o;
   assign pop_w   = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // Occupancy: a push and pop together leave the count unchanged.
   always_comb begin
      count_d = count_q;
      unique case ({push_w, pop_w})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; reset flushes the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage array, written at the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_w) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/tx_serializer_10b.sv
// 10b symbol serializer with running disparity and K28.5 idle fill.
// Optional sticky disparity checker: define TX_DISP_CHECK_EN.
module tx_serializer_10b #(
   parameter int               SYM_W     = 10,
   parameter int               BUF_DEPTH = 2,
   parameter logic [SYM_W-1:0] IDLE_RDN  = 10'b0011111010,
   parameter logic [SYM_W-1:0] IDLE_RDP  = 10'b1100000101
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_en,
   input  logic             sym_valid,
   input  logic [SYM_W-1:0] sym_in,
   output logic             sym_ready,
   output logic             disp_out,
   output logic             serial_out,
   output logic             sym_start,
   output logic             idle_active
`ifdef TX_DISP_CHECK_EN
   ,
   output logic             disp_err
`endif
);

   import tx_serdes_pkg::*;

   tx_state_e        state_q;
   logic [SYM_W-1:0] shreg_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [CNT_W-1:0] nxt_idx;
   logic             disp_q;
   logic             serial_q;
   logic             start_q;
   logic             idle_q;

   logic             fifo_full;
   logic             fifo_empty;
   logic [SYM_W-1:0] fifo_rdata;

   logic             load_w;
   logic             shift_w;
   logic             off_w;
   logic             stop_w;
   logic             pop_w;
   logic [SYM_W-1:0] ld_sym_d;
   logic             ld_idle_d;
   logic [3:0]       ld_ones;
   logic             disp_d;

   assign sym_ready   = !fifo_full;
   assign disp_out    = disp_q;
   assign serial_out  = serial_q;
   assign sym_start   = start_q;
   assign idle_active = idle_q;

   tx_sym_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (SYM_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (sym_valid),
      .wdata_i (sym_in),
      .pop_i   (pop_w),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Load from OFF via LOAD, or back-to-back at the last bit.
   always_comb begin
      off_w   = (state_q == OFF);
      shift_w = (state_q == SHIFT) && (bit_cnt_q != '0);
      load_w  = (state_q == LOAD) ||
                ((state_q == SHIFT) && (bit_cnt_q == '0) && tx_en);
      stop_w  = (state_q == SHIFT) && (bit_cnt_q == '0) && !tx_en;
      pop_w   = load_w && !fifo_empty;
      nxt_idx = bit_cnt_q - 1'b1;
   end

   // Pick data or RD-matched comma, and the RD it leaves behind.
   always_comb begin
      ld_idle_d = fifo_empty;
      ld_sym_d  = fifo_rdata;
      if (fifo_empty) ld_sym_d = disp_q ? IDLE_RDP : IDLE_RDN;
      ld_ones = ones_cnt10(ld_sym_d);
      disp_d  = disp_q;
      if (ld_ones > 4'd5)      disp_d = 1'b1;
      else if (ld_ones < 4'd5) disp_d = 1'b0;
   end

   // Serializer FSM with registered line outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= OFF;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         disp_q    <= 1'b0;
         serial_q  <= 1'b0;
         start_q   <= 1'b0;
         idle_q    <= 1'b0;
      end else begin
         unique case (1'b1)
            load_w: begin
               state_q   <= SHIFT;
               shreg_q   <= ld_sym_d;
               bit_cnt_q <= CNT_W'(SYM_W - 1);
               serial_q  <= ld_sym_d[SYM_W-1];
               start_q   <= 1'b1;
               idle_q    <= ld_idle_d;
               disp_q    <= disp_d;
            end
            shift_w: begin
               bit_cnt_q <= nxt_idx;
               serial_q  <= shreg_q[nxt_idx];
               start_q   <= 1'b0;
            end
            off_w: begin
               serial_q <= 1'b0;
               start_q  <= 1'b0;
               if (tx_en) state_q <= LOAD;
            end
            stop_w: begin
               state_q  <= OFF;
               serial_q <= 1'b0;
               start_q  <= 1'b0;
               idle_q   <= 1'b0;
            end
            default: begin
               state_q  <= OFF;
               serial_q <= 1'b0;
               start_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TX_DISP_CHECK_EN
   logic err_d;
   logic err_q;

   assign disp_err = err_q;

   // Flag data symbols that break 8b/10b disparity rules.
   always_comb begin
      err_d = 1'b0;
      if (load_w && !ld_idle_d) begin
         err_d = (ld_ones < 4'd4) || (ld_ones > 4'd6) ||
                 ((ld_ones == 4'd6) && disp_q) ||
                 ((ld_ones == 4'd4) && !disp_q);
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else if (err_d) err_q <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b.
// Disparity checker steps run when TX_DISP_CHECK_EN is defined.
module tb_tx_serializer_10b;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_en;
   logic       sym_valid;
   logic [9:0] sym_in;
   logic       sym_ready;
   logic       disp_out;
   logic       serial_out;
   logic       sym_start;
   logic       idle_active;
`ifdef TX_DISP_CHECK_EN
   logic       disp_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   localparam logic [9:0] I_N  = 10'b0011111010;
   localparam logic [9:0] I_P  = 10'b1100000101;
   localparam logic [9:0] D00  = 10'b1001110100;
   localparam logic [9:0] SB   = 10'b0110001011;
   localparam logic [9:0] SC   = 10'b0101000011;
   localparam logic [9:0] BAD  = 10'b1111110000;

   always #5 clk = ~clk;

   tx_serializer_10b dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_en       (tx_en),
      .sym_valid   (sym_valid),
      .sym_in      (sym_in),
      .sym_ready   (sym_ready),
      .disp_out    (disp_out),
      .serial_out  (serial_out),
      .sym_start   (sym_start),
      .idle_active (idle_active)
`ifdef TX_DISP_CHECK_EN
      ,
      .disp_err    (disp_err)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [9:0] obs,
                      input logic [9:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Receive one symbol starting at its bit 9; sym_valid is
   // dropped after the first edge, tx_en at bit index drop_at.
   task automatic rx_sym(input string tag,
                         input logic [9:0] exp_sym,
                         input logic exp_idle,
                         input logic exp_disp,
                         input int drop_at);
      logic [9:0] s;
      s = '0;
      for (int i = 9; i >= 0; i--) begin
         s[i] = serial_out;
         chk({tag, "_start"}, {9'd0, sym_start},
             {9'd0, (i == 9)});
         if (i == 9) begin
            chk({tag, "_idle"}, {9'd0, idle_active},
                {9'd0, exp_idle});
            chk({tag, "_disp"}, {9'd0, disp_out},
                {9'd0, exp_disp});
         end
         if (i == drop_at) tx_en = 1'b0;
         tick();
         sym_valid = 1'b0;
      end
      chk({tag, "_sym"}, s, exp_sym);
   endtask

   initial begin
      rst_n     = 1'b0;
      tx_en     = 1'b0;
      sym_valid = 1'b0;
      sym_in    = '0;
      #2;
      chk("rst_serial", {9'd0, serial_out}, 10'd0);
      chk("rst_disp",   {9'd0, disp_out},   10'd0);
      chk("rst_start",  {9'd0, sym_start},  10'd0);
      chk("rst_idle",   {9'd0, idle_active}, 10'd0);
      chk("rst_ready",  {9'd0, sym_ready},  10'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("off_serial", {9'd0, serial_out}, 10'd0);

      // Idle alternation from reset
      tx_en = 1'b1;
      tick();
      chk("lat1_serial", {9'd0, serial_out}, 10'd0);
      chk("lat1_start",  {9'd0, sym_start},  10'd0);
      tick();
      rx_sym("idle0", I_N, 1'b1, 1'b1, -1);
      rx_sym("idle1", I_P, 1'b1, 1'b0, -1);

      // D0.0 pushed during an idle
      chk("d00_ready", {9'd0, sym_ready}, 10'd1);
      sym_valid = 1'b1;
      sym_in    = D00;
      rx_sym("idle2", I_N, 1'b1, 1'b1, -1);
      rx_sym("d00",   D00, 1'b0, 1'b1, -1);
      rx_sym("idle3", I_P, 1'b1, 1'b0, -1);

      // tx_en dropped at bit_cnt 5: symbol completes, then OFF
      rx_sym("drop", I_N, 1'b1, 1'b1, 5);
      chk("off0_serial", {9'd0, serial_out}, 10'd0);
      chk("off0_start",  {9'd0, sym_start},  10'd0);
      chk("off0_idle",   {9'd0, idle_active}, 10'd0);
      chk("off0_disp",   {9'd0, disp_out},   10'd1);
      tick();
      chk("off1_serial", {9'd0, serial_out}, 10'd0);

      // Three pushes while OFF
      sym_valid = 1'b1;
      sym_in    = D00;
      chk("p0_ready", {9'd0, sym_ready}, 10'd1);
      tick();
      sym_in = SB;
      chk("p1_ready", {9'd0, sym_ready}, 10'd1);
      tick();
      sym_in = SC;
      chk("p2_ready", {9'd0, sym_ready}, 10'd0);
      tick();
      chk("p2_hold", {9'd0, sym_ready}, 10'd0);
      tx_en = 1'b1;
      tick();
      chk("p2_load", {9'd0, sym_ready}, 10'd0);
      tick();
      chk("p2_pop", {9'd0, sym_ready}, 10'd1);
      rx_sym("symA", D00, 1'b0, 1'b1, -1);
      rx_sym("symB", SB,  1'b0, 1'b1, -1);
      rx_sym("symC", SC,  1'b0, 1'b0, -1);

      // Reset mid-symbol with a full buffer
      sym_valid = 1'b1;
      sym_in    = D00;
      tick();
      sym_in = SC;
      tick();
      sym_valid = 1'b0;
      chk("pre_ready", {9'd0, sym_ready}, 10'd0);
      tick();
      chk("pre_serial", {9'd0, serial_out}, 10'd1);
      chk("pre_disp",   {9'd0, disp_out},   10'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_serial", {9'd0, serial_out}, 10'd0);
      chk("ar_disp",   {9'd0, disp_out},   10'd0);
      chk("ar_start",  {9'd0, sym_start},  10'd0);
      chk("ar_idle",   {9'd0, idle_active}, 10'd0);
      chk("ar_ready",  {9'd0, sym_ready},  10'd1);
      tick();
      chk("ar_hold", {9'd0, serial_out}, 10'd0);
      rst_n = 1'b1;
      tick();
      tick();
      rx_sym("flush", I_N, 1'b1, 1'b1, -1);
      rx_sym("idle4", I_P, 1'b1, 1'b0, -1);

`ifdef TX_DISP_CHECK_EN
      chk("derr_pre", {9'd0, disp_err}, 10'd0);
      sym_valid = 1'b1;
      sym_in    = BAD;
      rx_sym("idle5", I_N, 1'b1, 1'b1, -1);
      chk("derr_set", {9'd0, disp_err}, 10'd1);
      rx_sym("bad", BAD, 1'b0, 1'b1, -1);
      chk("derr_stk", {9'd0, disp_err}, 10'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("derr_rst", {9'd0, disp_err}, 10'd0);
      tick();
      rst_n = 1'b1;
`else
      rx_sym("idle5", I_N, 1'b1, 1'b1, -1);
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tx_serializer_10b.md
Name: tx_serializer_10b

Overview:
- Transmit-side stage directly downstream of the 8b/10b encoder in the IEEE1149.10 TX path.
- Accepts registered 10-bit code symbols through a 2-entry buffer with a valid/ready handshake and shifts them out serially, bit 9 ('a') first.
- Tracks running disparity (RD) and returns it to the encoder's disparity input.
- Inserts K28.5 comma idles matching the current RD whenever no data symbol is pending.

Parameters:
- SYM_W, 10, symbol width; fixed at 10, parameterised for readability only.
- BUF_DEPTH, 2, symbol buffer entries; power of two, minimum 2.
- IDLE_RDN, 10'b0011111010, K28.5 idle sent when RD is negative.
- IDLE_RDP, 10'b1100000101, K28.5 idle sent when RD is positive.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_en  in  1  serial transmit enable
- sym_valid  in  1  sym_in holds a symbol
- sym_in  in  10  encoded symbol; bit 9 is transmitted first
- sym_ready  out  1  buffer can accept a symbol
- disp_out  out  1  current RD (1 = positive), feeds encoder disp_in
- serial_out  out  1  serial line, registered
- sym_start  out  1  one-cycle pulse coinciding with bit 9 of each symbol on serial_out
- idle_active  out  1  symbol currently on the line is an inserted idle

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values:
  - state = OFF, buffer empty, bit_cnt = 0, shift register = 0.
  - serial_out = 0, disp_out = 0 (RD-), sym_start = 0, idle_active = 0, sym_ready = 1.
- Handshake:
  - A transfer occurs on a clk edge where sym_valid && sym_ready.
  - sym_ready = !full, with no same-cycle pass-through. When full, a pop in the same cycle does not raise ready until the next cycle.
  - Buffer writes are accepted in every state, including OFF.
- States:
  - OFF: serial_out = 0, nothing loaded. Goes to LOAD on the first cycle tx_en = 1.
  - LOAD: combinational decision, registered on the edge.
    - If the buffer is non-empty, pop the head into the shift register and set idle_active = 0.
    - If empty, load IDLE_RDN when disp_out = 0, else IDLE_RDP, and set idle_active = 1.
    - bit_cnt <= 9, sym_start <= 1, then go to SHIFT.
  - SHIFT: serial_out <= shreg[bit_cnt] each cycle; bit_cnt decrements. sym_start = 0 after the first bit.
    - At bit_cnt = 0 with tx_en = 1: reload on the same edge, giving back-to-back symbols with no gap bit.
    - At bit_cnt = 0 with tx_en = 0: go to OFF.
- tx_en deassertion mid-symbol: the current symbol completes all 10 bits, then OFF. A symbol is never truncated.
- Running disparity:
  - Updated on the load edge from the ones count of the loaded symbol: >5 sets RD+, <5 sets RD-, =5 leaves RD unchanged.
  - disp_out changes on the load edge, so the encoder sees the updated RD for the symbol it is currently encoding. Loop latency is 1 symbol.
- Latency:
  - A symbol accepted into an empty buffer while in SHIFT appears at the next symbol boundary.
  - From OFF, bit 9 reaches serial_out 2 cycles after tx_en rises.
- Simultaneous push and pop with buffer count 1: the count stays 1 and order is preserved (FIFO).
- Reset asserted mid-symbol: immediate return to reset values; the partial symbol is lost and the buffer is flushed.

Optional Feature:
- Macro: TX_DISP_CHECK_EN.
- When defined:
  - Adds output disp_err (1 bit, sticky, cleared only by rst_n).
  - disp_err is set on the load edge if a data symbol (not an idle) has a ones count outside {4,5,6}, or has 6 ones while RD+, or 4 ones while RD-.
  - Transmission is unaffected.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package tx_serdes_pkg holds:
  - SYM_W and the K28_5_RDN / K28_5_RDP constants.
  - The state enum typedef {OFF, LOAD, SHIFT}.
  - The function ones_cnt10 returning a 4-bit count.
- One sub-module, tx_sym_fifo (parameterised depth/width, full/empty flags, push/pop), instantiated once. Shift register, counter, RD and FSM stay in tx_serializer_10b.

Test Plan:
- Reset then tx_en = 1 with no data:
  - serial_out carries 0011111010 (6 ones, RD flips to +), then 1100000101 (RD back to -), alternating.
  - sym_start pulses every 10 cycles and idle_active = 1 throughout.
- Push D0.0 = 1001110100 (5 ones) during an idle:
  - It is sent at the next boundary with idle_active = 0 and disp_out unchanged; idles resume afterwards.
- Push 3 symbols back-to-back while OFF:
  - sym_ready drops after 2 accepts; the third is held until the first pop.
  - All 3 are sent contiguously with no gap and in order.
- Deassert tx_en at bit_cnt = 5:
  - The remaining 5 bits go out, then serial_out = 0 and state = OFF. Re-enable resumes with the buffered symbol.
- Assert rst_n = 0 mid-symbol with 1 buffered symbol:
  - All outputs go to reset values asynchronously; the buffer is empty after release and sym_ready = 1.
- With TX_DISP_CHECK_EN defined, push 1111110000 while RD+:
  - disp_err = 1 after the load edge and stays 1 until rst_n.
